// File: rtl/ysyx_22050039_mdu_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : ysyx_22050039_mdu_pkg
//  Purpose  : Shared op codes, FSM state type and op decoder for the
//             iterative multiply/divide unit.
//  Revision : 1.0  initial release
// ============================================================================
package ysyx_22050039_mdu_pkg;

  // MDU op codes (4-bit encoding shared with the core decoder)
  localparam logic [3:0] c_OP_MUL    = 4'd0;
  localparam logic [3:0] c_OP_MULH   = 4'd1;
  localparam logic [3:0] c_OP_MULHSU = 4'd2;
  localparam logic [3:0] c_OP_MULHU  = 4'd3;
  localparam logic [3:0] c_OP_DIV    = 4'd4;
  localparam logic [3:0] c_OP_DIVU   = 4'd5;
  localparam logic [3:0] c_OP_REM    = 4'd6;
  localparam logic [3:0] c_OP_REMU   = 4'd7;
  localparam logic [3:0] c_OP_MULW   = 4'd8;
  localparam logic [3:0] c_OP_DIVW   = 4'd9;
  localparam logic [3:0] c_OP_DIVUW  = 4'd10;
  localparam logic [3:0] c_OP_REMW   = 4'd11;
  localparam logic [3:0] c_OP_REMUW  = 4'd12;

  typedef enum logic [1:0] {
    MDU_IDLE = 2'd0,
    MDU_CALC = 2'd1,
    MDU_DONE = 2'd2
  } mdu_state_e;

  // Decoded attributes of one MDU op
  typedef struct packed {
    logic known;   // legal op code
    logic is_mul;  // multiply class (else divide class)
    logic is_rem;  // divide class returns remainder
    logic mul_hi;  // multiply returns upper half
    logic sgn1;    // src1 is signed
    logic sgn2;    // src2 is signed
    logic word;    // 32-bit W variant
  } mdu_dec_t;

  // W encodings degrade to the full-width op of the same kind when W ops
  // are not supported, so they never produce undefined results.
  function automatic mdu_dec_t mdu_decode(input logic [3:0] op, input logic has_word);
    mdu_dec_t d;
    d       = '0;
    d.known = 1'b1;
    case (op)
      c_OP_MUL:    d.is_mul = 1'b1;
      c_OP_MULH:   begin d.is_mul = 1'b1; d.mul_hi = 1'b1; d.sgn1 = 1'b1; d.sgn2 = 1'b1; end
      c_OP_MULHSU: begin d.is_mul = 1'b1; d.mul_hi = 1'b1; d.sgn1 = 1'b1; end
      c_OP_MULHU:  begin d.is_mul = 1'b1; d.mul_hi = 1'b1; end
      c_OP_DIV:    begin d.sgn1 = 1'b1; d.sgn2 = 1'b1; end
      c_OP_DIVU:   d.known = 1'b1;
      c_OP_REM:    begin d.is_rem = 1'b1; d.sgn1 = 1'b1; d.sgn2 = 1'b1; end
      c_OP_REMU:   d.is_rem = 1'b1;
      c_OP_MULW:   begin d.is_mul = 1'b1; d.word = 1'b1; d.sgn1 = 1'b1; d.sgn2 = 1'b1; end
      c_OP_DIVW:   begin d.word = 1'b1; d.sgn1 = 1'b1; d.sgn2 = 1'b1; end
      c_OP_DIVUW:  d.word = 1'b1;
      c_OP_REMW:   begin d.word = 1'b1; d.is_rem = 1'b1; d.sgn1 = 1'b1; d.sgn2 = 1'b1; end
      c_OP_REMUW:  begin d.word = 1'b1; d.is_rem = 1'b1; end
      default:     d.known = 1'b0;
    endcase
    if (!has_word) d.word = 1'b0;
    return d;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ysyx_22050039_div_iter.sv
`default_nettype none
// ============================================================================
//  Module   : ysyx_22050039_div_iter
//  Purpose  : One restoring-division step on unsigned magnitudes: shift the
//             next dividend bit into the partial remainder and subtract the
//             divisor when it fits.
//  Revision : 1.0  initial release
// ============================================================================
module ysyx_22050039_div_iter #(
  parameter int XLEN = 64
) (
  input  logic [XLEN-1:0] rem_i,
  input  logic            msb_i,
  input  logic [XLEN-1:0] divisor_i,
  output logic [XLEN-1:0] rem_o,
  output logic            q_bit_o
);

  logic [XLEN:0] w_shift;

  assign w_shift = {rem_i, msb_i};
  assign q_bit_o = (w_shift >= {1'b0, divisor_i});
  // The true remainder is always below the divisor, so XLEN bits suffice.
  assign rem_o   = w_shift[XLEN-1:0] - (q_bit_o ? divisor_i : {XLEN{1'b0}});

endmodule
`default_nettype wire

// File: rtl/ysyx_22050039_mdu.sv
`default_nettype none
// ============================================================================
//  Module   : ysyx_22050039_mdu
//  Purpose  : Iterative radix-2 RV64M multiply/divide unit with valid/ready
//             request and result handshakes. Divide-by-zero, signed overflow
//             and unknown ops complete on the accepting edge.
//  Revision : 1.0  initial release
// ============================================================================
module ysyx_22050039_mdu
  import ysyx_22050039_mdu_pkg::*;
#(
  parameter int XLEN     = 64,
  parameter int HAS_WORD = 1,
  parameter int OP_LEN   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [OP_LEN-1:0] op_i,
  input  logic [XLEN-1:0]   src1_i,
  input  logic [XLEN-1:0]   src2_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [XLEN-1:0]   out_result_o
);

  localparam int unsigned   c_CNT_W    = $clog2(XLEN + 1);
  localparam logic [XLEN-1:0] c_MIN_FULL = {1'b1, {(XLEN-1){1'b0}}};

  mdu_state_e            state_q, state_d;
  logic [c_CNT_W-1:0]    cnt_q, cnt_d;
  logic [2*XLEN-1:0]     acc_q, acc_d;      // mul: {partial, multiplier}; div: {remainder, dividend/quotient}
  logic [XLEN-1:0]       opb_q, opb_d;      // multiplicand or divisor magnitude
  logic                  neg_q, neg_d;      // final result needs negation
  logic                  mul_q, mul_d;
  logic                  rem_q, rem_d;
  logic                  hi_q, hi_d;
  logic                  word_q, word_d;
  logic [XLEN-1:0]       result_q, result_d;

  mdu_dec_t              w_dec;
  logic [XLEN-1:0]       w_a_eff, w_b_eff, w_a_res, w_min_neg, w_div_load;
  logic [XLEN-1:0]       w_a_mag, w_b_mag, w_special;
  logic                  w_sa, w_sb, w_div_zero, w_ovf, w_neg;
  logic [XLEN:0]         w_sum;
  logic [2*XLEN-1:0]     w_acc_mul, w_acc_div, w_acc_step, w_prod_s;
  logic [XLEN-1:0]       w_div_rem, w_dr, w_dr_s, w_fin_full, w_fin_word, w_fin;
  logic                  w_div_q;

  // Op codes wider than the 4-bit encoding are unknown unless upper bits are zero
  assign w_dec = ((op_i >> 4) == '0) ? mdu_decode(op_i[3:0], HAS_WORD != 0) : '0;

  // ---------------------------------------------------------------- operands
  assign w_sa    = w_dec.sgn1 & w_a_eff[XLEN-1];
  assign w_sb    = w_dec.sgn2 & w_b_eff[XLEN-1];
  assign w_a_mag = w_sa ? -w_a_eff : w_a_eff;
  assign w_b_mag = w_sb ? -w_b_eff : w_b_eff;

  assign w_div_zero = ~w_dec.is_mul & (w_b_eff == '0);
  assign w_ovf      = ~w_dec.is_mul & w_dec.sgn1 & w_dec.sgn2 &
                      (w_a_eff == w_min_neg) & (&w_b_eff);
  // Remainder follows the dividend sign; product and quotient the sign xor
  assign w_neg      = (w_dec.is_rem & ~w_dec.is_mul) ? w_sa : (w_sa ^ w_sb);

  assign w_special  = w_div_zero ? (w_dec.is_rem ? w_a_res : {XLEN{1'b1}})
                                 : (w_dec.is_rem ? {XLEN{1'b0}} : w_a_res);

  // ---------------------------------------------------------- iteration step
  assign w_sum     = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opb_q} : {(XLEN+1){1'b0}});
  assign w_acc_mul = {w_sum, acc_q[XLEN-1:1]};

  ysyx_22050039_div_iter #(.XLEN(XLEN)) u_div_iter (
    .rem_i     (acc_q[2*XLEN-1:XLEN]),
    .msb_i     (acc_q[XLEN-1]),
    .divisor_i (opb_q),
    .rem_o     (w_div_rem),
    .q_bit_o   (w_div_q)
  );

  assign w_acc_div  = {w_div_rem, acc_q[XLEN-2:0], w_div_q};
  assign w_acc_step = mul_q ? w_acc_mul : w_acc_div;

  // ------------------------------------------------------------ final result
  assign w_prod_s   = neg_q ? -w_acc_step : w_acc_step;
  assign w_dr       = rem_q ? w_acc_step[2*XLEN-1:XLEN] : w_acc_step[XLEN-1:0];
  assign w_dr_s     = neg_q ? -w_dr : w_dr;
  assign w_fin_full = mul_q ? (hi_q ? w_prod_s[2*XLEN-1:XLEN] : w_prod_s[XLEN-1:0]) : w_dr_s;
  assign w_fin      = word_q ? w_fin_word : w_fin_full;

  generate
    if (HAS_WORD != 0) begin : g_word_ops
      localparam int unsigned c_EXT = XLEN - 32;
      logic [31:0] w_pw, w_pw_s;

      assign w_a_eff    = w_dec.word ? {{c_EXT{w_dec.sgn1 & src1_i[31]}}, src1_i[31:0]} : src1_i;
      assign w_b_eff    = w_dec.word ? {{c_EXT{w_dec.sgn2 & src2_i[31]}}, src2_i[31:0]} : src2_i;
      assign w_a_res    = w_dec.word ? {{c_EXT{src1_i[31]}}, src1_i[31:0]} : src1_i;
      assign w_min_neg  = w_dec.word ? {{(c_EXT+1){1'b1}}, 31'd0} : c_MIN_FULL;
      // A 32-step divide consumes the dividend from bit XLEN-1 downwards
      assign w_div_load = w_dec.word ? (w_a_mag << 32) : w_a_mag;

      // After 32 shift-add steps the product sits at acc[XLEN+31:XLEN-32]
      assign w_pw       = w_acc_step[XLEN-1:XLEN-32];
      assign w_pw_s     = neg_q ? -w_pw : w_pw;
      assign w_fin_word = mul_q ? {{c_EXT{w_pw_s[31]}}, w_pw_s}
                                : {{c_EXT{w_dr_s[31]}}, w_dr_s[31:0]};
    end else begin : g_full_only
      assign w_a_eff    = src1_i;
      assign w_b_eff    = src2_i;
      assign w_a_res    = src1_i;
      assign w_min_neg  = c_MIN_FULL;
      assign w_div_load = w_a_mag;
      assign w_fin_word = w_fin_full;
    end
  endgenerate

  // Next-state and datapath update for accept / iterate / handshake / flush
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    opb_d    = opb_q;
    neg_d    = neg_q;
    mul_d    = mul_q;
    rem_d    = rem_q;
    hi_d     = hi_q;
    word_d   = word_q;
    result_d = result_q;
    case (state_q)
      MDU_IDLE: begin
        if (in_valid_i) begin
          mul_d  = w_dec.is_mul;
          rem_d  = w_dec.is_rem;
          hi_d   = w_dec.mul_hi;
          word_d = w_dec.word;
          neg_d  = w_neg;
          if (!w_dec.known) begin
            result_d = '0;
            cnt_d    = '0;
            state_d  = MDU_DONE;
          end else if (w_div_zero || w_ovf) begin
            result_d = w_special;
            cnt_d    = '0;
            state_d  = MDU_DONE;
          end else begin
            cnt_d   = w_dec.word ? c_CNT_W'(32) : c_CNT_W'(XLEN);
            acc_d   = w_dec.is_mul ? {{XLEN{1'b0}}, w_b_mag} : {{XLEN{1'b0}}, w_div_load};
            opb_d   = w_dec.is_mul ? w_a_mag : w_b_mag;
            state_d = MDU_CALC;
          end
        end
      end
      MDU_CALC: begin
        acc_d = w_acc_step;
        cnt_d = cnt_q - c_CNT_W'(1);
        if (cnt_q == c_CNT_W'(1)) begin
          result_d = w_fin;
          state_d  = MDU_DONE;
        end
      end
      MDU_DONE: begin
        if (out_ready_i) state_d = MDU_IDLE;
      end
      default: state_d = MDU_IDLE;
    endcase
    // A redirect discards whatever was in flight, including a finishing result
    if (flush_i) begin
      state_d  = MDU_IDLE;
      cnt_d    = '0;
      result_d = result_q;
    end
  end

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= MDU_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      opb_q    <= '0;
      neg_q    <= 1'b0;
      mul_q    <= 1'b0;
      rem_q    <= 1'b0;
      hi_q     <= 1'b0;
      word_q   <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      opb_q    <= opb_d;
      neg_q    <= neg_d;
      mul_q    <= mul_d;
      rem_q    <= rem_d;
      hi_q     <= hi_d;
      word_q   <= word_d;
      result_q <= result_d;
    end
  end

  assign in_ready_o   = (state_q == MDU_IDLE);
  assign out_valid_o  = (state_q == MDU_DONE);
  assign out_result_o = result_q;

endmodule
`default_nettype wire
